pc_update_unit: RTL and testbench
=================================

Name: pc_update_unit

Overview:
- Program-counter stage directly downstream of the PC-input selector mux.
- Registers the selected 32-bit next-PC under unconditional or branch-conditional write control.
- Runs a two-cycle exception entry sequence: save EPC, then jump to the exception vector.
- Drives PC to instruction memory and EPC to the register datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_00FC, PC loaded on exception entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- next_pc  in  32  next-PC candidate from the selector mux.
- pc_write  in  1  unconditional PC write.
- pc_write_cond  in  1  conditional PC write; qualified by branch_type.
- branch_type  in  2  branch condition: 0=EQ, 1=NE, 2=GT, 3=LE.
- alu_zero  in  1  ALU result zero flag.
- alu_gt  in  1  ALU signed greater-than flag.
- exc_req  in  1  exception request from control (overflow or bad opcode).
- exc_code  in  2  cause code accompanying exc_req.
- pc_out  out  32  current PC.
- epc_out  out  32  saved exception PC.
- cause_out  out  2  latched cause code.
- busy  out  1  high while the exception sequence runs.

Behaviour:
- Reset values: pc_out=RESET_PC, epc_out=0, cause_out=0, busy=0, state=RUN.
- Reset dominates all other inputs, including mid-sequence; the FSM returns to RUN.
- States: RUN, EXC_SAVE, EXC_JUMP.
- Branch condition taken = EQ: alu_zero; NE: !alu_zero; GT: alu_gt; LE: !alu_gt.
- RUN, no exception:
  - Write enable = pc_write | (pc_write_cond & taken).
  - When enabled, pc_out <= next_pc, visible the cycle after the enabling edge (1-cycle latency).
  - When not enabled, pc_out holds.
- RUN, exc_req=1:
  - exc_req wins over any simultaneous PC write; the write is dropped.
  - cause_out <= exc_code; go to EXC_SAVE.
  - busy rises the following cycle.
- EXC_SAVE:
  - epc_out <= pc_out - 4 (modulo 2^32; PC was already incremented at fetch).
  - pc_out unchanged; go to EXC_JUMP.
- EXC_JUMP:
  - pc_out <= EXC_VECTOR; go to RUN.
  - busy deasserts in the RUN cycle.
- While busy, pc_write, pc_write_cond and exc_req are ignored; a second exc_req is not queued.
- epc_out and cause_out hold their values until the next exception or reset.
- Subtraction wraps: pc_out=0 gives epc_out=32'hFFFF_FFFC.
- busy is a registered output decoded from state (high in EXC_SAVE and EXC_JUMP).

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - In RUN, an enabled write with next_pc[1:0]!=0 is suppressed.
  - It is treated as an internal exception with cause_out <= 2'b11 and follows the same EXC_SAVE/EXC_JUMP path.
  - An external exc_req in the same cycle takes priority and its exc_code is latched.
- Undefined:
  - next_pc is loaded unchecked.
  - Cause code 3 is only produced via exc_code.

Decomposition:
- Shared package: state encoding (RUN=2'd0, EXC_SAVE=2'd1, EXC_JUMP=2'd2), branch_type encodings, cause codes (OVF=0, OPCODE=1, MISALIGN=3), default RESET_PC/EXC_VECTOR constants.
- One natural sub-module: branch_cond_eval (combinational; branch_type, alu_zero, alu_gt -> taken).
- FSM and registers stay in pc_update_unit.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with pc_write=1, next_pc=32'h40 -> pc_out=0, busy=0; after release with pc_write=0, pc_out stays 0.
- Unconditional write: pc_write=1, next_pc=32'h0000_0004 -> pc_out=4 next cycle; pc_write=0 -> holds 4.
- Conditional branches: pc_write_cond=1, branch_type=NE, alu_zero=1, next_pc=32'h80 -> pc unchanged. Then alu_zero=0 -> pc=32'h80. Cover GT/LE with alu_gt=1/0.
- Exception entry: pc_out=32'h24, exc_req=1, exc_code=0, pc_write=1 in the same cycle -> write dropped; busy for 2 cycles; epc_out=32'h20; pc_out=32'hFC; cause_out=0. exc_req held high during busy -> no re-entry.
- Reset mid-sequence: assert reset in EXC_SAVE -> next cycle pc_out=0, epc_out=0, cause_out=0, busy=0, state RUN.
- With PC_MISALIGN_CHECK_EN: pc_write=1, next_pc=32'h0000_0102 at pc_out=8 -> no load; epc_out=4; cause_out=3; pc_out=32'hFC. Without the macro -> pc_out=32'h102.

Source files
------------

// File: rtl/pc_update_unit_pkg.sv
// rtl/pc_update_unit_pkg.sv - shared encodings and defaults for the PC update stage
package pc_update_unit_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_SAVE = 2'd1,
    EXC_JUMP = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    BR_EQ = 2'd0,
    BR_NE = 2'd1,
    BR_GT = 2'd2,
    BR_LE = 2'd3
  } branch_type_e;

  typedef enum logic [1:0] {
    CAUSE_OVF      = 2'd0,
    CAUSE_OPCODE   = 2'd1,
    CAUSE_MISALIGN = 2'd3
  } cause_e;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_00FC;

endpackage

// File: rtl/pc_update_unit_branch_cond_eval.sv
// rtl/pc_update_unit_branch_cond_eval.sv - branch condition evaluation from ALU flags
module pc_update_unit_branch_cond_eval
  import pc_update_unit_pkg::*;
(
  input  logic [1:0] branch_type,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch_type_e'(branch_type))
      BR_EQ:   taken = alu_zero;
      BR_NE:   taken = !alu_zero;
      BR_GT:   taken = alu_gt;
      BR_LE:   taken = !alu_gt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - PC register with branch-qualified writes and two-cycle exception entry
// Optional PC_MISALIGN_CHECK_EN turns misaligned PC writes into internal exceptions.
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_type,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [1:0]  cause_out,
  output logic        busy
);

  pc_state_e   state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] epc_q, epc_next;
  logic [1:0]  cause_q, cause_next;
  logic        busy_q;
  logic        taken;
  logic        wr_en;

  pc_update_unit_branch_cond_eval u_branch_cond_eval (
    .branch_type (branch_type),
    .alu_zero    (alu_zero),
    .alu_gt      (alu_gt),
    .taken       (taken)
  );

  assign wr_en = pc_write | (pc_write_cond & taken);

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    epc_next   = epc_q;
    cause_next = cause_q;
    case (state)
      RUN: begin
        // External exception outranks both PC writes and the misalign trap
        if (exc_req) begin
          cause_next = exc_code;
          state_next = EXC_SAVE;
        end
`ifdef PC_MISALIGN_CHECK_EN
        else if (wr_en && (next_pc[1:0] != 2'b00)) begin
          cause_next = CAUSE_MISALIGN;
          state_next = EXC_SAVE;
        end
`endif
        else if (wr_en) begin
          pc_next = next_pc;
        end
      end
      EXC_SAVE: begin
        // PC was already advanced at fetch, so the faulting instruction sits 4 back
        epc_next   = pc_q - 32'd4;
        state_next = EXC_JUMP;
      end
      EXC_JUMP: begin
        pc_next    = EXC_VECTOR;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= 32'h0;
      cause_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      epc_q   <= epc_next;
      cause_q <= cause_next;
      busy_q  <= (state_next != RUN);
    end
  end

  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign cause_out = cause_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed and randomized checks of pc_update_unit against a cycle model
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic [1:0]  cause_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_epc = 32'h0;
  logic [1:0]  m_cause = 2'b00;
  int          m_left = 0;

  pc_update_unit dut (
    .clk           (clk),
    .reset         (reset),
    .next_pc       (next_pc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_type   (branch_type),
    .alu_zero      (alu_zero),
    .alu_gt        (alu_gt),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .cause_out     (cause_out),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic branch_taken(input logic [1:0] bt, input logic az, input logic agt);
    if (bt == 2'd0) return az;
    if (bt == 2'd1) return !az;
    if (bt == 2'd2) return agt;
    return !agt;
  endfunction

  // Cycle model: m_left counts remaining busy cycles of an exception entry
  task automatic model_edge();
    logic we;
    we = pc_write | (pc_write_cond & branch_taken(branch_type, alu_zero, alu_gt));
    if (reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_left = 0;
    end else if (m_left == 2) begin
      m_epc = m_pc - 32'd4;
      m_left = 1;
    end else if (m_left == 1) begin
      m_pc = 32'hFC;
      m_left = 0;
    end else if (exc_req) begin
      m_cause = exc_code;
      m_left = 2;
    end else if (we) begin
`ifdef PC_MISALIGN_CHECK_EN
      if (next_pc % 4 != 0) begin
        m_cause = 2'd3;
        m_left = 2;
      end else
        m_pc = next_pc;
`else
      m_pc = next_pc;
`endif
    end
  endtask

  task automatic step(input logic rst, input logic pw, input logic pwc, input logic [1:0] bt,
                      input logic az, input logic agt, input logic er, input logic [1:0] ec,
                      input logic [31:0] npc);
    @(negedge clk);
    reset = rst; pc_write = pw; pc_write_cond = pwc; branch_type = bt;
    alu_zero = az; alu_gt = agt; exc_req = er; exc_code = ec; next_pc = npc;
    @(posedge clk);
    model_edge();
    #1;
    check("pc", pc_out, m_pc);
    check("epc", epc_out, m_epc);
    check("cause", {30'b0, cause_out}, {30'b0, m_cause});
    check("busy", {31'b0, busy}, {31'b0, m_left != 0});
  endtask

  initial begin
    // Reset with a pending write, then idle
    step(1, 1, 0, 0, 0, 0, 0, 0, 32'h40);
    step(1, 1, 0, 0, 0, 0, 0, 0, 32'h40);
    check("rst_pc", pc_out, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
    check("idle_pc", pc_out, 32'h0);

    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h4);
    check("wr_pc", pc_out, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8);
    check("hold_pc", pc_out, 32'h4);

    // Conditional writes across all four branch types
    step(0, 0, 1, 2'd1, 1, 0, 0, 0, 32'h80);
    check("ne_not_taken", pc_out, 32'h4);
    step(0, 0, 1, 2'd1, 0, 0, 0, 0, 32'h80);
    check("ne_taken", pc_out, 32'h80);
    step(0, 0, 1, 2'd2, 0, 1, 0, 0, 32'h90);
    check("gt_taken", pc_out, 32'h90);
    step(0, 0, 1, 2'd3, 0, 1, 0, 0, 32'hA0);
    check("le_not_taken", pc_out, 32'h90);
    step(0, 0, 1, 2'd3, 0, 0, 0, 0, 32'hA0);
    check("le_taken", pc_out, 32'hA0);
    step(0, 0, 1, 2'd0, 1, 0, 0, 0, 32'h10);
    check("eq_taken", pc_out, 32'h10);

    // Exception with simultaneous write, exc_req held through busy
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h24);
    step(0, 1, 0, 0, 0, 0, 1, 2'd0, 32'h40);
    check("exc_drop_wr", pc_out, 32'h24);
    check("exc_busy1", {31'b0, busy}, 32'h1);
    step(0, 1, 0, 0, 0, 0, 1, 2'd2, 32'h40);
    check("exc_epc", epc_out, 32'h20);
    step(0, 1, 0, 0, 0, 0, 1, 2'd2, 32'h40);
    check("exc_vec", pc_out, 32'hFC);
    check("exc_cause", {30'b0, cause_out}, 32'h0);
    check("exc_done", {31'b0, busy}, 32'h0);

    // Reset in EXC_SAVE, then wrapping EPC from pc=0
    step(0, 0, 0, 0, 0, 0, 1, 2'd1, 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_epc", epc_out, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 2'd2, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("wrap_epc", epc_out, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    // Misaligned write
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h8);
    step(0, 1, 0, 0, 0, 0, 0, 0, 32'h102);
`ifdef PC_MISALIGN_CHECK_EN
    check("mis_noload", pc_out, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    check("mis_epc", epc_out, 32'h4);
    check("mis_cause", {30'b0, cause_out}, 32'h3);
    check("mis_vec", pc_out, 32'hFC);
`else
    check("mis_load", pc_out, 32'h102);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] npc;
      npc = $urandom;
      if ($urandom_range(3) != 0) npc[1:0] = 2'b00;
      step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
           2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom_range(15) == 0, 2'($urandom_range(3)), npc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
